// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and the command record for the ALU issue stage.
package alu_pkg;

    localparam logic [3:0] ALU_ADD    = 4'h0;
    localparam logic [3:0] ALU_SUB    = 4'h1;
    localparam logic [3:0] ALU_AND    = 4'h2;
    localparam logic [3:0] ALU_OR     = 4'h3;
    localparam logic [3:0] ALU_XOR    = 4'h4;
    localparam logic [3:0] ALU_SHL    = 4'h5;
    localparam logic [3:0] ALU_SHR    = 4'h6;
    localparam logic [3:0] ALU_ASR    = 4'h7;
    localparam logic [3:0] ALU_MUL    = 4'h8;
    localparam logic [3:0] ALU_OP_MAX = 4'h8;

    localparam int FLG_Z = 0;
    localparam int FLG_C = 1;
    localparam int FLG_V = 2;
    localparam int FLG_N = 3;

    // Tag field width of a stored command; the stage's TAG_W must match it.
    localparam int CMD_TAG_W = 4;

    typedef struct packed {
        logic [7:0]           a;
        logic [7:0]           b;
        logic [3:0]           op;
        logic [CMD_TAG_W-1:0] tag;
    } alu_cmd_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Command, ALU-side and result/status signals of the issue stage; slave is the stage itself.
interface alu_issue_if #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic [3:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic [7:0]       alu_a;
    logic [7:0]       alu_b;
    logic [3:0]       alu_op;
    logic [7:0]       alu_result;
    logic [3:0]       alu_flags;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_result;
    logic [3:0]       out_flags;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;
    logic             clr_sticky;
    logic             sticky_carry;
    logic             sticky_ovf;
    logic [CNT_W-1:0] illegal_cnt;

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_tag, alu_result, alu_flags, out_ready, clr_sticky,
        output in_ready, alu_a, alu_b, alu_op, out_valid, out_result, out_flags, out_illegal,
               out_tag, sticky_carry, sticky_ovf, illegal_cnt
    );

    modport master (
        output in_valid, in_a, in_b, in_op, in_tag, alu_result, alu_flags, out_ready, clr_sticky,
        input  in_ready, alu_a, alu_b, alu_op, out_valid, out_result, out_flags, out_illegal,
               out_tag, sticky_carry, sticky_ovf, illegal_cnt
    );
endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO of ALU commands; head is all-zero whenever the FIFO is empty.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  logic     pop,
    input  alu_cmd_t wdata,
    output alu_cmd_t head,
    output logic     full,
    output logic     empty
);
    localparam int AW = $clog2(DEPTH);

    alu_cmd_t        mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally at DEPTH, which is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage for the 8-bit ALU: queues commands, feeds the ALU from the FIFO head,
// registers the result with valid/ready and keeps sticky carry/overflow and illegal-op status.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = CMD_TAG_W,
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic rst_n,
    alu_issue_if.slave bus
);
    alu_cmd_t         wr_cmd;
    alu_cmd_t         head;
    logic             full;
    logic             empty;
    logic             push;
    logic             issue;
    logic             head_illegal;

    logic             out_valid_q;
    logic [7:0]       out_result_q;
    logic [3:0]       out_flags_q;
    logic             out_illegal_q;
    logic [TAG_W-1:0] out_tag_q;
    logic             sticky_carry_q;
    logic             sticky_ovf_q;
    logic [CNT_W-1:0] illegal_cnt_q;

    assign wr_cmd.a   = bus.in_a;
    assign wr_cmd.b   = bus.in_b;
    assign wr_cmd.op  = bus.in_op;
    assign wr_cmd.tag = bus.in_tag;

    // in_ready looks only at occupancy, so a full FIFO refuses even when popping.
    assign bus.in_ready = !full;
    assign push         = bus.in_valid && !full;
    assign issue        = !empty && (!out_valid_q || bus.out_ready);
    assign head_illegal = (head.op > ALU_OP_MAX);

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (issue),
        .wdata (wr_cmd),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    assign bus.alu_a  = head.a;
    assign bus.alu_b  = head.b;
    assign bus.alu_op = head.op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_flags_q   <= '0;
            out_illegal_q <= 1'b0;
            out_tag_q     <= '0;
        end else if (issue) begin
            out_valid_q   <= 1'b1;
            out_result_q  <= bus.alu_result;
            out_flags_q   <= bus.alu_flags;
            out_illegal_q <= head_illegal;
            out_tag_q     <= head.tag;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q   <= 1'b0;
        end
    end

    // Status updates from a capture take priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_carry_q <= 1'b0;
            sticky_ovf_q   <= 1'b0;
            illegal_cnt_q  <= '0;
        end else begin
            if (issue && bus.alu_flags[FLG_C]) sticky_carry_q <= 1'b1;
            else if (bus.clr_sticky)           sticky_carry_q <= 1'b0;

            if (issue && bus.alu_flags[FLG_V]) sticky_ovf_q <= 1'b1;
            else if (bus.clr_sticky)           sticky_ovf_q <= 1'b0;

            if (issue && head_illegal) begin
                if (illegal_cnt_q != '1) illegal_cnt_q <= illegal_cnt_q + 1'b1;
            end else if (bus.clr_sticky) begin
                illegal_cnt_q <= '0;
            end
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_result   = out_result_q;
    assign bus.out_flags    = out_flags_q;
    assign bus.out_illegal  = out_illegal_q;
    assign bus.out_tag      = out_tag_q;
    assign bus.sticky_carry = sticky_carry_q;
    assign bus.sticky_ovf   = sticky_ovf_q;
    assign bus.illegal_cnt  = illegal_cnt_q;
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Upstream issue stage for the 8-bit combinational ALU (ops 0x0–0x8: add, sub, and, or, xor, shl, shr, asr, mul).
- Buffers incoming commands {a, b, op, tag} in a small FIFO and presents the head entry to the ALU's operand/op inputs.
- Captures the ALU's combinational result and flags into a valid/ready output register.
- Keeps sticky carry/overflow status and a saturating illegal-op counter for software/status readout.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- TAG_W, 4, width of the command tag carried alongside each operation.
- CNT_W, 8, width of the saturating illegal-op counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  command valid.
- in_ready  out  1  FIFO can accept a command.
- in_a  in  8  operand A.
- in_b  in  8  operand B.
- in_op  in  4  ALU opcode.
- in_tag  in  TAG_W  command tag.
- alu_a  out  8  to ALU a.
- alu_b  out  8  to ALU b.
- alu_op  out  4  to ALU op.
- alu_result  in  8  from ALU result.
- alu_flags  in  4  from ALU {negative, overflow, carry, zero}.
- out_valid  out  1  result register holds data.
- out_ready  in  1  consumer accepts result.
- out_result  out  8  captured result.
- out_flags  out  4  captured {negative, overflow, carry, zero}.
- out_illegal  out  1  captured op was > 0x8.
- out_tag  out  TAG_W  tag of captured command.
- clr_sticky  in  1  clear sticky status.
- sticky_carry  out  1  OR of carry over all captures since clear/reset.
- sticky_ovf  out  1  OR of overflow over all captures since clear/reset.
- illegal_cnt  out  CNT_W  count of illegal ops captured; saturating.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO is emptied.
  - out_valid, out_result, out_flags, out_illegal, out_tag, sticky_carry, sticky_ovf and illegal_cnt all go to 0 immediately.
  - in_ready=1 during and after reset.
- Reset mid-operation discards all queued and captured commands; nothing is replayed.
- in_ready = !full, purely from the occupancy count. There is no bypass: when full, in_ready=0 even if a pop occurs that cycle.
- Push occurs when in_valid && in_ready.
- alu_a/alu_b/alu_op are driven combinationally from the FIFO head. They are all-zero when the FIFO is empty.
- Issue condition: fifo_not_empty && (!out_valid || out_ready).
- On issue, at the clock edge:
  - The head entry is popped.
  - out_result <= alu_result, out_flags <= alu_flags, out_tag <= head tag, out_illegal <= (head op > 4'h8).
  - out_valid <= 1.
- If out_valid && out_ready with no issue, out_valid <= 0.
- While out_valid && !out_ready, all out_* signals are held stable.
- Latency: a command pushed into an empty FIFO at edge N is captured at edge N+1, so out_valid is high after edge N+1.
- Sustained throughput is 1 command per cycle.
- Simultaneous push and pop when not full leaves the count unchanged.
- Read and write pointers are log2(DEPTH) bits with natural wrap. The count is log2(DEPTH)+1 bits.
- Sticky bits:
  - Set on any capture whose carry or overflow flag is 1.
  - clr_sticky clears them.
  - If a set and clr_sticky occur in the same cycle, set wins.
- illegal_cnt increments by 1 on each capture with out_illegal=1 and saturates at 2^CNT_W-1. clr_sticky also clears it, with increment winning in the same cycle.
- An illegal op is still issued normally; its result is whatever the ALU returns (0x00, zero=1).

Decomposition:
- alu_pkg holds:
  - opcode localparams ALU_ADD=4'h0 … ALU_MUL=4'h8 and ALU_OP_MAX=4'h8;
  - flag bit indices FLG_Z=0, FLG_C=1, FLG_V=2, FLG_N=3;
  - typedef alu_cmd_t {a, b, op, tag}.
- One sub-module, alu_cmd_fifo: a parameterised synchronous FIFO of alu_cmd_t with push/pop/full/empty/head outputs. Issue control, output register, sticky and counter logic stay in the top.

Test Plan:
- Push {a=0xFF, b=0x01, op=0x0, tag=3}, out_ready=1 → one cycle after push: out_valid=1, out_result=0x00, flags Z=1 C=1 V=0 N=0, tag=3, sticky_carry=1.
- Push {0x7F, 0x01, op=0x0} → out_result=0x80, V=1, N=1, C=0; sticky_ovf=1.
- DEPTH=4, out_ready=0, push tags 0–5 → tag 0 held in the output register, tags 1–4 in the FIFO, in_ready=0, tag 5 stalls. Raise out_ready → tags 0–5 emerge in order, one per cycle.
- Push op=0xA → out_result=0x00, Z=1, out_illegal=1, illegal_cnt=1. After 300 illegal ops, illegal_cnt=0xFF.
- Assert clr_sticky in the same cycle as a carry-producing capture → sticky_carry remains 1. clr_sticky alone next cycle → sticky_carry=0.
- Assert rst_n=0 with 3 commands queued and out_valid=1 → out_valid=0 immediately and in_ready=1. After release, a new command completes with correct result and no stale tags appear.
